// File: rtl/rx_peak_detector_if.sv
// Bus between the correlator and the peak detector: one strobe with 16 signed
// correlation results going in, and the detection report and status flags coming out.
interface rx_peak_detector_if;
  logic               icorr_valid;
  logic signed [40:0] icorrelation_seq_0;
  logic signed [40:0] icorrelation_seq_1;
  logic signed [40:0] icorrelation_seq_2;
  logic signed [40:0] icorrelation_seq_3;
  logic signed [40:0] icorrelation_seq_4;
  logic signed [40:0] icorrelation_seq_5;
  logic signed [40:0] icorrelation_seq_6;
  logic signed [40:0] icorrelation_seq_7;
  logic signed [40:0] icorrelation_seq_8;
  logic signed [40:0] icorrelation_seq_9;
  logic signed [40:0] icorrelation_seq_10;
  logic signed [40:0] icorrelation_seq_11;
  logic signed [40:0] icorrelation_seq_12;
  logic signed [40:0] icorrelation_seq_13;
  logic signed [40:0] icorrelation_seq_14;
  logic signed [40:0] icorrelation_seq_15;
  logic               odetect;
  logic [3:0]         oseq_id;
  logic [39:0]        opeak_mag;
  logic [31:0]        opeak_index;
  logic               obusy;
  logic               ooverrun;

  modport master (
    output icorr_valid,
    output icorrelation_seq_0, icorrelation_seq_1, icorrelation_seq_2, icorrelation_seq_3,
    output icorrelation_seq_4, icorrelation_seq_5, icorrelation_seq_6, icorrelation_seq_7,
    output icorrelation_seq_8, icorrelation_seq_9, icorrelation_seq_10, icorrelation_seq_11,
    output icorrelation_seq_12, icorrelation_seq_13, icorrelation_seq_14, icorrelation_seq_15,
    input  odetect, oseq_id, opeak_mag, opeak_index, obusy, ooverrun
  );

  modport slave (
    input  icorr_valid,
    input  icorrelation_seq_0, icorrelation_seq_1, icorrelation_seq_2, icorrelation_seq_3,
    input  icorrelation_seq_4, icorrelation_seq_5, icorrelation_seq_6, icorrelation_seq_7,
    input  icorrelation_seq_8, icorrelation_seq_9, icorrelation_seq_10, icorrelation_seq_11,
    input  icorrelation_seq_12, icorrelation_seq_13, icorrelation_seq_14, icorrelation_seq_15,
    output odetect, oseq_id, opeak_mag, opeak_index, obusy, ooverrun
  );
endinterface

// File: rtl/rx_peak_detector.sv
// Receiver peak detector: latches 16 correlation results per update, scans them
// serially for the largest magnitude, and tracks the strongest frame peak across a
// threshold-triggered window of WINDOW frames before reporting it.
module rx_peak_detector #(
  parameter logic [39:0] THRESHOLD = 40'd1000000,
  parameter int unsigned WINDOW    = 64
) (
  input logic               crx_clk,
  input logic               rrx_rst,
  input logic               erx_en,
  rx_peak_detector_if.slave bus
);

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

  typedef enum logic [1:0] {
    DET_SEARCH = 2'd0,
    DET_TRACK  = 2'd1,
    DET_REPORT = 2'd2
  } det_state_t;

  localparam logic [15:0] W_LAST = 16'(WINDOW);

  // |x| of a 41-bit signed value, squeezed into 40 bits; only -2^40 overflows and saturates.
  function automatic logic [39:0] f_mag(input logic signed [40:0] x);
    logic [40:0] v_neg;
    v_neg = (~x) + 41'd1;
    if (x[40]) begin
      if (v_neg[40]) f_mag = {40{1'b1}};
      else           f_mag = v_neg[39:0];
    end else begin
      f_mag = x[39:0];
    end
  endfunction

  logic               w_clr;
  logic signed [40:0] w_in [16];

  scan_state_t        r_scan_state;
  logic signed [40:0] r_shadow [16];
  logic [3:0]         r_idx;
  logic               r_busy;
  logic               r_overrun;
  logic [31:0]        r_frame_cnt;
  logic [31:0]        r_frame_no;
  logic [39:0]        r_best_mag;
  logic [3:0]         r_best_idx;
  logic               r_done;

  det_state_t         r_det_state;
  logic [15:0]        r_win_cnt;
  logic [39:0]        r_peak_mag;
  logic [3:0]         r_peak_seq;
  logic [31:0]        r_peak_idx;
  logic               r_odetect;
  logic [3:0]         r_oseq_id;
  logic [39:0]        r_opeak_mag;
  logic [31:0]        r_opeak_index;

  logic [39:0]        w_cand_mag;
  logic               w_take;
  logic [15:0]        w_win_next;
  logic               w_above;
  logic               w_beats;
  logic [39:0]        w_trk_mag;
  logic [3:0]         w_trk_seq;
  logic [31:0]        w_trk_idx;

  // Disable behaves exactly like reset.
  assign w_clr = rrx_rst | ~erx_en;

  assign w_in[0]  = bus.icorrelation_seq_0;
  assign w_in[1]  = bus.icorrelation_seq_1;
  assign w_in[2]  = bus.icorrelation_seq_2;
  assign w_in[3]  = bus.icorrelation_seq_3;
  assign w_in[4]  = bus.icorrelation_seq_4;
  assign w_in[5]  = bus.icorrelation_seq_5;
  assign w_in[6]  = bus.icorrelation_seq_6;
  assign w_in[7]  = bus.icorrelation_seq_7;
  assign w_in[8]  = bus.icorrelation_seq_8;
  assign w_in[9]  = bus.icorrelation_seq_9;
  assign w_in[10] = bus.icorrelation_seq_10;
  assign w_in[11] = bus.icorrelation_seq_11;
  assign w_in[12] = bus.icorrelation_seq_12;
  assign w_in[13] = bus.icorrelation_seq_13;
  assign w_in[14] = bus.icorrelation_seq_14;
  assign w_in[15] = bus.icorrelation_seq_15;

  assign bus.obusy       = r_busy;
  assign bus.ooverrun    = r_overrun;
  assign bus.odetect     = r_odetect;
  assign bus.oseq_id     = r_oseq_id;
  assign bus.opeak_mag   = r_opeak_mag;
  assign bus.opeak_index = r_opeak_index;

  // Scanner candidate: index 0 seeds the best, later ones win only when strictly larger.
  always_comb begin
    w_cand_mag = f_mag(r_shadow[r_idx]);
    if (r_idx == 4'd0) begin
      w_take = 1'b1;
    end else begin
      w_take = (w_cand_mag > r_best_mag);
    end
  end

  // Capture/scan FSM: latch the bank on an accepted strobe, then walk idx 0..15.
  always_ff @(posedge crx_clk) begin
    if (w_clr) begin
      r_scan_state <= SCAN_IDLE;
      for (int i = 0; i < 16; i++) r_shadow[i] <= 41'sd0;
      r_idx        <= 4'd0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_cnt  <= 32'd0;
      r_frame_no   <= 32'd0;
      r_best_mag   <= 40'd0;
      r_best_idx   <= 4'd0;
      r_done       <= 1'b0;
    end else begin
      r_overrun <= bus.icorr_valid & r_busy;
      r_done    <= 1'b0;
      case (r_scan_state)
        SCAN_IDLE: begin
          if (bus.icorr_valid) begin
            for (int i = 0; i < 16; i++) r_shadow[i] <= w_in[i];
            r_frame_no   <= r_frame_cnt;
            r_frame_cnt  <= r_frame_cnt + 32'd1;
            r_idx        <= 4'd0;
            r_busy       <= 1'b1;
            r_scan_state <= SCAN_RUN;
          end
        end
        SCAN_RUN: begin
          if (w_take) begin
            r_best_mag <= w_cand_mag;
            r_best_idx <= r_idx;
          end
          if (r_idx == 4'd15) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_scan_state <= SCAN_IDLE;
          end
          r_idx <= r_idx + 4'd1;
        end
        default: begin
          r_busy       <= 1'b0;
          r_scan_state <= SCAN_IDLE;
        end
      endcase
    end
  end

  // Window bookkeeping: next count, threshold test and the peak kept after this frame.
  always_comb begin
    w_win_next = r_win_cnt + 16'd1;
    w_above    = (r_best_mag > THRESHOLD);
    w_beats    = (r_best_mag > r_peak_mag);
    if (w_beats) begin
      w_trk_mag = r_best_mag;
      w_trk_seq = r_best_idx;
      w_trk_idx = r_frame_no;
    end else begin
      w_trk_mag = r_peak_mag;
      w_trk_seq = r_peak_seq;
      w_trk_idx = r_peak_idx;
    end
  end

  // Detector FSM: open a window on a frame over threshold, track the peak, report once.
  always_ff @(posedge crx_clk) begin
    if (w_clr) begin
      r_det_state   <= DET_SEARCH;
      r_win_cnt     <= 16'd0;
      r_peak_mag    <= 40'd0;
      r_peak_seq    <= 4'd0;
      r_peak_idx    <= 32'd0;
      r_odetect     <= 1'b0;
      r_oseq_id     <= 4'd0;
      r_opeak_mag   <= 40'd0;
      r_opeak_index <= 32'd0;
    end else begin
      r_odetect <= 1'b0;
      case (r_det_state)
        DET_SEARCH: begin
          if (r_done && w_above) begin
            r_peak_mag <= r_best_mag;
            r_peak_seq <= r_best_idx;
            r_peak_idx <= r_frame_no;
            r_win_cnt  <= 16'd1;
            if (W_LAST == 16'd1) begin
              r_odetect     <= 1'b1;
              r_oseq_id     <= r_best_idx;
              r_opeak_mag   <= r_best_mag;
              r_opeak_index <= r_frame_no;
              r_det_state   <= DET_REPORT;
            end else begin
              r_det_state   <= DET_TRACK;
            end
          end
        end
        DET_TRACK: begin
          if (r_done) begin
            r_win_cnt  <= w_win_next;
            r_peak_mag <= w_trk_mag;
            r_peak_seq <= w_trk_seq;
            r_peak_idx <= w_trk_idx;
            if (w_win_next == W_LAST) begin
              r_odetect     <= 1'b1;
              r_oseq_id     <= w_trk_seq;
              r_opeak_mag   <= w_trk_mag;
              r_opeak_index <= w_trk_idx;
              r_det_state   <= DET_REPORT;
            end
          end
        end
        DET_REPORT: begin
          r_det_state <= DET_SEARCH;
        end
        default: begin
          r_det_state <= DET_SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_peak_detector.sv
// Bench for rx_peak_detector: directed frames, a frame-level reference model that
// predicts every output cycle by cycle, and literal checks of the expected reports.
module tb_rx_peak_detector;
  localparam logic [39:0] TH  = 40'd1000000;
  localparam int          WIN = 4;

  typedef struct packed {
    logic [3:0]  seq;
    logic [39:0] mag;
    logic [31:0] idx;
  } rep_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  int   cyc = 0;

  rx_peak_detector_if ifc ();

  rx_peak_detector #(.THRESHOLD(TH), .WINDOW(WIN)) dut (
    .crx_clk (clk),
    .rrx_rst (rst),
    .erx_en  (en),
    .bus     (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  rep_t        exp_det [int];
  bit          exp_ovr [int];
  bit          exp_clr [int];
  int          m_busy_lo = -100;
  int          m_busy_hi = -100;
  logic [31:0] m_cnt = 32'd0;
  bit          m_inwin = 1'b0;
  int          m_wcnt = 0;
  rep_t        m_pk = '0;

  logic signed [40:0] fr [16];

  function automatic logic [39:0] ref_mag(input logic signed [40:0] x);
    longint xv;
    longint a;
    xv = longint'(x);
    a  = (xv < 0) ? -xv : xv;
    if (a > 64'sd1099511627775) a = 64'sd1099511627775;
    return a[39:0];
  endfunction

  task automatic model_strobe(input int c0);
    logic [39:0] fmax;
    logic [3:0]  fid;
    logic [31:0] fno;
    if (c0 - 1 >= m_busy_lo && c0 - 1 <= m_busy_hi) begin
      exp_ovr[c0] = 1'b1;
    end else begin
      fno       = m_cnt;
      m_cnt     = m_cnt + 32'd1;
      m_busy_lo = c0;
      m_busy_hi = c0 + 15;
      fmax      = ref_mag(fr[0]);
      fid       = 4'd0;
      for (int i = 1; i < 16; i++) begin
        if (ref_mag(fr[i]) > fmax) begin
          fmax = ref_mag(fr[i]);
          fid  = 4'(i);
        end
      end
      if (!m_inwin) begin
        if (fmax > TH) begin
          m_inwin = 1'b1;
          m_wcnt  = 1;
          m_pk    = '{seq: fid, mag: fmax, idx: fno};
        end
      end else begin
        m_wcnt++;
        if (fmax > m_pk.mag) m_pk = '{seq: fid, mag: fmax, idx: fno};
      end
      if (m_inwin && m_wcnt == WIN) begin
        exp_det[c0 + 17] = m_pk;
        m_inwin = 1'b0;
      end
    end
  endtask

  task automatic model_reset(input int r);
    int ks[$];
    foreach (exp_det[k]) if (k >= r) ks.push_back(k);
    foreach (ks[j]) exp_det.delete(ks[j]);
    ks.delete();
    foreach (exp_ovr[k]) if (k >= r) ks.push_back(k);
    foreach (ks[j]) exp_ovr.delete(ks[j]);
    exp_clr[r] = 1'b1;
    m_cnt   = 32'd0;
    m_inwin = 1'b0;
    m_wcnt  = 0;
    if (m_busy_hi >= r) m_busy_hi = r - 1;
  endtask

  // ---------------- per-cycle compare ----------------
  bit   chk_en = 1'b0;
  rep_t cur = '0;
  int   det_cnt = 0;
  int   ovr_cnt = 0;
  int   last_det = -1;
  int   last_ovr = -1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        if (exp_clr.exists(cyc)) cur = '0;
        if (exp_det.exists(cyc)) cur = exp_det[cyc];
        chk("odetect", 64'(ifc.odetect), 64'(exp_det.exists(cyc)));
        chk("ooverrun", 64'(ifc.ooverrun), 64'(exp_ovr.exists(cyc)));
        chk("obusy", 64'(ifc.obusy), 64'(cyc >= m_busy_lo && cyc <= m_busy_hi));
        chk("oseq_id", 64'(ifc.oseq_id), 64'(cur.seq));
        chk("opeak_mag", 64'(ifc.opeak_mag), 64'(cur.mag));
        chk("opeak_index", 64'(ifc.opeak_index), 64'(cur.idx));
        if (ifc.odetect === 1'b1) begin
          det_cnt++;
          last_det = cyc;
        end
        if (ifc.ooverrun === 1'b1) begin
          ovr_cnt++;
          last_ovr = cyc;
        end
      end
    end
  end

  // ---------------- stimulus helpers (entered and left just after a negedge) ----------------
  task automatic zero_fr();
    for (int i = 0; i < 16; i++) fr[i] = 41'sd0;
  endtask

  task automatic strobe(output int c0);
    ifc.icorrelation_seq_0  = fr[0];
    ifc.icorrelation_seq_1  = fr[1];
    ifc.icorrelation_seq_2  = fr[2];
    ifc.icorrelation_seq_3  = fr[3];
    ifc.icorrelation_seq_4  = fr[4];
    ifc.icorrelation_seq_5  = fr[5];
    ifc.icorrelation_seq_6  = fr[6];
    ifc.icorrelation_seq_7  = fr[7];
    ifc.icorrelation_seq_8  = fr[8];
    ifc.icorrelation_seq_9  = fr[9];
    ifc.icorrelation_seq_10 = fr[10];
    ifc.icorrelation_seq_11 = fr[11];
    ifc.icorrelation_seq_12 = fr[12];
    ifc.icorrelation_seq_13 = fr[13];
    ifc.icorrelation_seq_14 = fr[14];
    ifc.icorrelation_seq_15 = fr[15];
    ifc.icorr_valid = 1'b1;
    c0 = cyc + 1;
    model_strobe(c0);
    @(negedge clk);
    ifc.icorr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(output int c0);
    strobe(c0);
    idle(16);
  endtask

  task automatic pulse_clear(input bit use_en);
    if (use_en) en = 1'b0;
    else        rst = 1'b1;
    model_reset(cyc + 1);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
  endtask

  task automatic chk_report(input string name, input int d0, input logic [3:0] s,
                            input logic [39:0] m, input logic [31:0] ix);
    chk({name, " count"}, 64'(det_cnt - d0), 64'd1);
    chk({name, " seq"}, 64'(ifc.oseq_id), 64'(s));
    chk({name, " mag"}, 64'(ifc.opeak_mag), 64'(m));
    chk({name, " index"}, 64'(ifc.opeak_index), 64'(ix));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int c;
    int c13;
    int cd;
    int d0;
    rst = 1'b1;
    en  = 1'b1;
    ifc.icorr_valid = 1'b0;
    zero_fr();
    idle(3);
    chk_en = 1'b1;
    rst    = 1'b0;
    idle(1);
    chk("reset odetect", 64'(ifc.odetect), 64'd0);
    chk("reset opeak_mag", 64'(ifc.opeak_mag), 64'd0);
    chk("reset obusy", 64'(ifc.obusy), 64'd0);

    // 200 frames at +/-500000: never above threshold
    for (int f = 0; f < 200; f++) begin
      for (int i = 0; i < 16; i++) fr[i] = (((i + f) % 2) == 1) ? 41'sd500000 : -41'sd500000;
      send(c);
    end
    idle(4);
    chk("quiet detects", 64'(det_cnt), 64'd0);
    chk("quiet overruns", 64'(ovr_cnt), 64'd0);

    // Window of 4 opened by frame 10, seq 5
    pulse_clear(1'b0);
    d0 = det_cnt;
    zero_fr();
    for (int f = 0; f < 10; f++) send(c);
    fr[5] = 41'sd2000000;
    send(c);
    zero_fr();
    send(c);
    send(c);
    send(c13);
    idle(20);
    chk_report("win4", d0, 4'd5, 40'd2000000, 32'd10);
    chk("win4 latency", 64'(last_det - c13), 64'd17);

    // -2^40 saturates and wins over larger-looking finite values (frames 14..17)
    d0 = det_cnt;
    zero_fr();
    fr[3] = -41'sd3000000;
    fr[7] = 41'sd2500000;
    fr[9] = {1'b1, 40'd0};
    send(c);
    zero_fr();
    for (int f = 0; f < 3; f++) send(c);
    idle(20);
    chk_report("sat", d0, 4'd9, 40'hFF_FFFF_FFFF, 32'd14);

    // Same frame without seq 9 (frames 18..21)
    d0 = det_cnt;
    fr[3] = -41'sd3000000;
    fr[7] = 41'sd2500000;
    send(c);
    zero_fr();
    for (int f = 0; f < 3; f++) send(c);
    idle(20);
    chk_report("neg", d0, 4'd3, 40'd3000000, 32'd18);

    // Tie keeps the lowest index (frames 22..25)
    d0 = det_cnt;
    fr[2] = 41'sd5000000;
    fr[9] = 41'sd5000000;
    send(c);
    zero_fr();
    for (int f = 0; f < 3; f++) send(c);
    idle(20);
    chk_report("tie", d0, 4'd2, 40'd5000000, 32'd22);

    // Later stronger frame inside the window wins (frames 26..29)
    d0 = det_cnt;
    fr[1] = 41'sd1500000;
    send(c);
    zero_fr();
    send(c);
    send(c);
    fr[12] = 41'sd4000000;
    send(c);
    zero_fr();
    idle(20);
    chk_report("track", d0, 4'd12, 40'd4000000, 32'd29);

    // Strobe 5 cycles into a scan is dropped; counter and shadow untouched
    pulse_clear(1'b0);
    d0 = det_cnt;
    fr[0] = 41'sd2000000;
    strobe(c);
    idle(4);
    zero_fr();
    fr[4] = 41'sd9000000;
    strobe(cd);
    idle(11);
    zero_fr();
    for (int f = 0; f < 3; f++) send(c);
    idle(20);
    chk("overrun count", 64'(ovr_cnt), 64'd1);
    chk("overrun cycle", 64'(last_ovr - cd), 64'd0);
    chk_report("overrun", d0, 4'd0, 40'd2000000, 32'd0);

    // Reset after frame 2 of a window: no report, outputs cleared, counting restarts
    d0 = det_cnt;
    fr[6] = 41'sd7000000;
    send(c);
    zero_fr();
    send(c);
    idle(3);
    pulse_clear(1'b0);
    idle(2);
    chk("rst odetect count", 64'(det_cnt - d0), 64'd0);
    chk("rst oseq_id", 64'(ifc.oseq_id), 64'd0);
    chk("rst opeak_mag", 64'(ifc.opeak_mag), 64'd0);
    chk("rst opeak_index", 64'(ifc.opeak_index), 64'd0);
    send(c);
    fr[8] = 41'sd3000000;
    send(c);
    zero_fr();
    for (int f = 0; f < 3; f++) send(c);
    idle(20);
    chk_report("after rst", d0, 4'd8, 40'd3000000, 32'd1);

    // Enable dropped mid-scan of frame 2 of a window
    d0 = det_cnt;
    fr[6] = 41'sd7000000;
    send(c);
    zero_fr();
    strobe(c);
    idle(6);
    pulse_clear(1'b1);
    idle(2);
    chk("en odetect count", 64'(det_cnt - d0), 64'd0);
    chk("en obusy", 64'(ifc.obusy), 64'd0);
    chk("en opeak_mag", 64'(ifc.opeak_mag), 64'd0);
    chk("en opeak_index", 64'(ifc.opeak_index), 64'd0);
    send(c);
    fr[10] = 41'sd6000000;
    send(c);
    zero_fr();
    for (int f = 0; f < 3; f++) send(c);
    idle(25);
    chk_report("after en", d0, 4'd10, 40'd6000000, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
